// File: rtl/mult_sched_pkg.sv
// Shared constants and the in-flight slot type for the multiplier issue/writeback scheduler.
package mult_pkg;
    localparam int MULT_LATENCY = 4;
    localparam int MULT_REGW    = 5;

    localparam logic [MULT_REGW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [MULT_REGW-1:0] dest;
    } mult_slot_t;
endpackage

// File: rtl/mult_sched_if.sv
// Decode, multiplier-completion and register-file write-port signals of the scheduler.
// Handshake: decode holds dec_valid with a stable instruction; the instruction is accepted in
// any cycle where sched_stall is low, and a multiply is launched exactly when sched_m0_oper is high.
interface mult_sched_if #(
    parameter int REGW = 5
);
    logic            dec_valid;
    logic            dec_mult;
    logic [REGW-1:0] dec_srca;
    logic [REGW-1:0] dec_srcb;
    logic            dec_uses_a;
    logic            dec_uses_b;
    logic [REGW-1:0] dec_regdest;
    logic            sched_stall;
    logic            sched_m0_oper;
    logic            mw_oper;
    logic            alu_wb_req;
    logic            alu_wb_grant;
    logic            wb_mult_sel;
    logic [REGW-1:0] wb_regdest;
    logic [2:0]      sched_inflight;
    logic            sched_err;

    modport master (
        output dec_valid, dec_mult, dec_srca, dec_srcb, dec_uses_a, dec_uses_b, dec_regdest,
        output mw_oper, alu_wb_req,
        input  sched_stall, sched_m0_oper, alu_wb_grant, wb_mult_sel, wb_regdest,
        input  sched_inflight, sched_err
    );

    modport slave (
        input  dec_valid, dec_mult, dec_srca, dec_srcb, dec_uses_a, dec_uses_b, dec_regdest,
        input  mw_oper, alu_wb_req,
        output sched_stall, sched_m0_oper, alu_wb_grant, wb_mult_sel, wb_regdest,
        output sched_inflight, sched_err
    );
endinterface

// File: rtl/mult_hazard_cmp.sv
// Compares one source register against every in-flight multiply destination.
module mult_hazard_cmp
    import mult_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY
) (
    input  logic [MULT_REGW-1:0]     src,
    input  logic                     uses,
    input  mult_slot_t [LATENCY-1:0] slots,
    output logic                     hit
);
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            if (slots[k].valid && (slots[k].dest == src)) hit = 1'b1;
        end
        // r0 is hard-wired, so a pending write to it never blocks a reader.
        if (!uses || (src == REG_ZERO)) hit = 1'b0;
    end
endmodule

// File: rtl/mult_sched.sv
// Multiply issue scheduler: RAW stall against in-flight results, slot tracking,
// write-port arbitration (multiplier over ALU) and a sticky completion-mismatch flag.
module mult_sched
    import mult_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY,
    parameter int REGW    = MULT_REGW
) (
    input logic         clock,
    input logic         reset,
    mult_sched_if.slave bus
);
    mult_slot_t [LATENCY-1:0] slot_q;
    mult_slot_t               slot_in;
    logic                     haz_a;
    logic                     haz_b;
    logic                     stall;
    logic                     launch;
    logic                     err_q;
    logic [2:0]               inflight;

    mult_hazard_cmp #(.LATENCY(LATENCY)) u_cmp_a (
        .src   (bus.dec_srca),
        .uses  (bus.dec_uses_a),
        .slots (slot_q),
        .hit   (haz_a)
    );

    mult_hazard_cmp #(.LATENCY(LATENCY)) u_cmp_b (
        .src   (bus.dec_srcb),
        .uses  (bus.dec_uses_b),
        .slots (slot_q),
        .hit   (haz_b)
    );

    assign stall  = bus.dec_valid & (haz_a | haz_b);
    assign launch = bus.dec_valid & bus.dec_mult & ~stall;

    always_comb begin
        slot_in.valid = launch;
        slot_in.dest  = launch ? bus.dec_regdest : REG_ZERO;
    end

    always_comb begin
        inflight = 3'd0;
        for (int k = 0; k < LATENCY; k++) begin
            inflight = inflight + {2'b00, slot_q[k].valid};
        end
    end

    // The oldest slot is the multiplier's predicted completion for this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
            err_q  <= 1'b0;
        end else begin
            slot_q <= {slot_q[LATENCY-2:0], slot_in};
            if (bus.mw_oper != slot_q[LATENCY-1].valid) err_q <= 1'b1;
        end
    end

    assign bus.sched_stall    = stall;
    assign bus.sched_m0_oper  = launch;
    assign bus.wb_mult_sel    = slot_q[LATENCY-1].valid;
    assign bus.wb_regdest     = slot_q[LATENCY-1].dest;
    assign bus.alu_wb_grant   = bus.alu_wb_req & ~slot_q[LATENCY-1].valid;
    assign bus.sched_inflight = inflight;
    assign bus.sched_err      = err_q;
endmodule

// File: doc/mult_sched.md
# mult_sched

Issue and writeback scheduler for the fixed-latency signed multiplier pipeline (m0 → m1 → … → writeback). It sits between decode and the multiplier pipeline entrance:
- admits multiply requests into m0;
- tracks every in-flight multiply's destination register in a shift register;
- stalls decode on read-after-write hazards against in-flight results;
- arbitrates the single register-file write port between multiplier completions and ALU writebacks.

## Interface
Parameters:
- LATENCY, 4, cycles from issue cycle T to the multiplier result cycle (≥2).
- REGW, 5, register index width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- dec_valid  in  1  decode holds a valid instruction this cycle.
- dec_mult  in  1  that instruction is a multiply (meaningful only with dec_valid).
- dec_srca, dec_srcb  in  REGW  source registers read by the instruction.
- dec_uses_a, dec_uses_b  in  1  the corresponding source is actually read.
- dec_regdest  in  REGW  destination register.
- sched_stall  out  1  decode must hold its instruction.
- sched_m0_oper  out  1  launch into m0 this cycle (m0 captures on the next edge).
- mw_oper  in  1  multiplier pipeline end presents a result this cycle.
- alu_wb_req  in  1  ALU result wants the write port.
- alu_wb_grant  out  1  ALU write permitted this cycle.
- wb_mult_sel  out  1  write port carries the multiplier result.
- wb_regdest  out  REGW  destination of the multiplier write (0 when wb_mult_sel=0).
- sched_inflight  out  3  number of valid slots (LATENCY ≤ 7).
- sched_err  out  1  sticky: mw_oper disagreed with prediction.

## Operation
- Slot array: slot[0..LATENCY-1], each holding {valid, dest}.
- Every edge, slot[k] ← slot[k-1] for k ≥ 1, and slot[0] ← {sched_m0_oper, dec_regdest}. When not launching, slot[0] ← {0, 0}.
- Hazard:
  - hazA = dec_uses_a & dec_srca≠0 & ∃k: slot[k].valid & slot[k].dest==dec_srca.
  - hazB is the same for source b.
  - All slots are compared, including slot[LATENCY-1]; there is no bypass.
- sched_stall = dec_valid & (hazA | hazB). It applies to multiply and non-multiply instructions alike.
- sched_m0_oper = dec_valid & dec_mult & ~sched_stall. This is combinational.
- Destination register 0:
  - is never a hazard source;
  - still occupies a slot and a write cycle.
- WAW between multiplies is allowed without a stall, because fixed latency preserves write order.
- Writeback arbitration:
  - wb_mult_sel = slot[LATENCY-1].valid.
  - wb_regdest = slot[LATENCY-1].dest.
  - alu_wb_grant = alu_wb_req & ~wb_mult_sel. The multiplier always wins and the ALU retries next cycle.
- Check: sched_err is set when mw_oper ≠ slot[LATENCY-1].valid. It clears only on reset.
- sched_inflight = popcount of slot valids.

## Timing
- Reset values:
  - all slots {0,0};
  - sched_err=0.
- Resulting output values during reset:
  - sched_inflight=0, wb_mult_sel=0, wb_regdest=0;
  - alu_wb_grant=alu_wb_req;
  - sched_stall=0, so launches are combinationally possible.
- Multiply issued in cycle T:
  - slot[k] valid in cycle T+1+k;
  - wb_mult_sel=1 in cycle T+LATENCY;
  - a dependent reader stalls through cycle T+LATENCY and may issue in T+LATENCY+1.
- Back-to-back issues in consecutive cycles are legal; throughput is 1 per cycle.
- Simultaneous ALU request and multiplier completion: ALU denied in that cycle, no other effect.
- Reset mid-operation: all in-flight slots are dropped immediately. The pipeline is reset by the same signal, so sched_err must not assert afterwards.

## Structure
- Package mult_pkg:
  - constant MULT_LATENCY (default for LATENCY);
  - REG_ZERO;
  - typedef mult_slot_t {valid, dest[REGW-1:0]}.
- One sub-module, mult_hazard_cmp: combinational comparison of one source index against all slots, returning a hit. It is instantiated twice (a, b).
- Slot shift register, arbitration and error flag live in mult_sched.

## Test plan
- Reset then idle: dec_valid=0, alu_wb_req=1 → alu_wb_grant=1 every cycle; sched_inflight=0; sched_err=0.
- Multiply r5 issued at T, then add reading r5 held from T+1:
  - sched_stall=1 in cycles T+1..T+4 (LATENCY=4);
  - stall drops in T+5;
  - wb_mult_sel=1 and wb_regdest=5 in T+4.
- Four consecutive multiplies to r1..r4 with mw_oper driven correctly:
  - sched_inflight reaches 4;
  - wb_regdest sequence 1,2,3,4 in T+4..T+7;
  - sched_err stays 0.
- ALU request held continuously across a multiplier completion at cycle C → alu_wb_grant=0 only in C, 1 before and after.
- Multiply with dec_regdest=0 followed by a reader of r0 → no stall; wb_mult_sel=1 with wb_regdest=0 at T+4.
- mw_oper forced 1 in a cycle with no prediction → sched_err=1 from the next cycle, persisting until reset; an asynchronous reset mid-stream clears slots and sched_err without waiting for a clock edge.
